// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared constants for the 4x4 shift-and-add multiplier.
//            Holds the state encoding, operand/product widths and the
//            iteration count.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int W_OP   = 4;
  localparam int W_PROD = 8;
  localparam int N_ITER = 4;
  localparam int W_CNT  = 2;

  // One-hot encoding: busy/done decode from a single state bit each.
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_CALC = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  // Counter value during the final iteration.
  localparam logic [W_CNT-1:0] LAST_CNT = W_CNT'(N_ITER - 1);

endpackage : mult_pkg
`default_nettype wire

// File: rtl/Somador4Bits.sv
`default_nettype none
// ============================================================================
// Module   : Somador4Bits
// Purpose  : 4-bit unsigned ripple-carry adder (carry-in fixed at 0).
// Ports    : a, b      - 4-bit addends
//            sum       - 4-bit sum
//            carry_out - carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
module Somador4Bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[4];

endmodule : Somador4Bits
`default_nettype wire

// File: rtl/multiplicador_4bits.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_4bits
// Purpose  : Sequential 4x4 unsigned shift-and-add multiplier. One operand
//            pair per start pulse, four iterations through Somador4Bits,
//            8-bit registered product with busy/done handshake.
// Ports    : clk     - clock, rising edge
//            rst_n   - synchronous active-low reset
//            start   - request, sampled only in IDLE
//            a, b    - multiplicand / multiplier, captured on accepted start
//            product - registered a*b, held until next completion or reset
//            busy    - high while iterating
//            done    - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module multiplicador_4bits
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_OP-1:0]   a,
  input  logic [W_OP-1:0]   b,
  output logic [W_PROD-1:0] product,
  output logic              busy,
  output logic              done
);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [W_CNT-1:0] cnt;

  logic [W_OP-1:0]  m;
  logic [W_OP-1:0]  q;
  logic [W_OP-1:0]  acc;
  logic [W_OP-1:0]  addend;
  logic [W_OP-1:0]  sum;
  logic             carry_out;

  logic             accept;
  logic             last_iter;

  assign accept    = (state == ST_IDLE) && start;
  assign last_iter = (state == ST_CALC) && (cnt == LAST_CNT);

  // Operand mux: add the multiplicand only when the current multiplier bit is set.
  assign addend = q[0] ? m : '0;

  Somador4Bits u_adder (
    .a         (acc),
    .b         (addend),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CALC)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = accept    ? ST_CALC : ST_IDLE;
      ST_CALC: state_next = last_iter ? ST_DONE : ST_CALC;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the one-hot state register.
  always_comb begin
    busy = (state == ST_CALC);
    done = (state == ST_DONE);
  end

  // Shift-register datapath. {carry_out,sum,q} shifted right by one:
  // carry_out becomes the new acc MSB, sum[0] drops into the q MSB and
  // the consumed multiplier bit q[0] falls off the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      product <= '0;
    end else if (accept) begin
      m   <= a;
      q   <= b;
      acc <= '0;
    end else if (state == ST_CALC) begin
      acc <= {carry_out, sum[W_OP-1:1]};
      q   <= {sum[0], q[W_OP-1:1]};
      if (last_iter)
        product <= {carry_out, sum, q[W_OP-1:1]};
    end
  end

endmodule : multiplicador_4bits
`default_nettype wire
